// File: rtl/icache_assoc.sv
// icache_assoc: set-associative, multi-word-block instruction cache with a block-refill FSM.
// Define ICACHE_STATS_EN to build the saturating hit_count/miss_count registers.
module icache_assoc #(
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        dbgState
);

  localparam int IDX  = $clog2(SETS);
  localparam int WOFF = $clog2(WORDS);
  localparam int TAGW = 30 - IDX - WOFF;
  localparam int CW   = (WOFF > 0) ? WOFF : 1;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} stateType;

  stateType        state;
  logic [CW-1:0]   cnt;
  logic [TAGW-1:0] latTag;
  logic [IDX-1:0]  latIdx;
  logic [WW-1:0]   vicWay;

  logic            valid [SETS][WAYS];
  logic [TAGW-1:0] tags  [SETS][WAYS];
  logic [31:0]     data  [SETS][WAYS][WORDS];
  logic [WW-1:0]   repl  [SETS];

  logic [TAGW-1:0] reqTag;
  logic [IDX-1:0]  reqIdx;
  logic [CW-1:0]   reqWord;
  logic [1:0]      unusedAddr;

  logic            lookHit;
  logic [WW-1:0]   hitWay;
  logic            anyInvalid;
  logic [WW-1:0]   victim;
  logic            fetchHit;
  logic            missStart;
  logic            wordDone;
  logic            lastWord;

  assign reqTag     = imemaddr[31 -: TAGW];
  assign reqIdx     = imemaddr[2 + WOFF +: IDX];
  assign unusedAddr = imemaddr[1:0];

  generate
    if (WOFF > 0) begin : gWord
      assign reqWord = imemaddr[2 +: WOFF];
      assign iaddr   = {latTag, latIdx, cnt, 2'b00};
    end else begin : gNoWord
      assign reqWord = '0;
      assign iaddr   = {latTag, latIdx, 2'b00};
    end
  endgenerate

  always_comb begin
    lookHit = 1'b0;
    hitWay  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lookHit && valid[reqIdx][w] && (tags[reqIdx][w] == reqTag)) begin
        lookHit = 1'b1;
        hitWay  = WW'(w);
      end
    end
  end

  // Invalid ways are consumed lowest-first; only a full set falls back to LRU/round-robin.
  always_comb begin
    anyInvalid = 1'b0;
    victim     = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!anyInvalid && !valid[reqIdx][w]) begin
        anyInvalid = 1'b1;
        victim     = WW'(w);
      end
    end
    if (!anyInvalid && (WAYS > 1)) victim = repl[reqIdx];
  end

  assign fetchHit  = (state == IDLE) && imemREN && lookHit && !iflush;
  assign missStart = (state == IDLE) && imemREN && !lookHit && !iflush;

  // Refill handshake: iREN is held high for the whole FILL state; a word is
  // transferred in each cycle where iREN=1 and iwait=0, and iload is sampled then.
  assign wordDone = (state == FILL) && !iwait;
  assign lastWord = (cnt == CW'(WORDS - 1));

  assign ihit     = fetchHit;
  assign imemload = fetchHit ? data[reqIdx][hitWay][reqWord] : '0;
  assign iREN     = (state == FILL);
  assign dbgState = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      latTag <= '0;
      latIdx <= '0;
      vicWay <= '0;
      for (int s = 0; s < SETS; s++) begin
        repl[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end
    end else if (iflush) begin
      state <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) valid[s][w] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fetchHit) begin
            if (WAYS == 2) repl[reqIdx] <= ~hitWay;
          end else if (missStart) begin
            latTag <= reqTag;
            latIdx <= reqIdx;
            vicWay <= victim;
            cnt    <= '0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (wordDone) begin
            if (lastWord) begin
              cnt                   <= '0;
              valid[latIdx][vicWay] <= 1'b1;
              if (WAYS == 2) repl[latIdx] <= ~vicWay;
              else if (WAYS == 4) repl[latIdx] <= repl[latIdx] + WW'(1);
              state <= IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tags need no reset: a way is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (!RST && !iflush && wordDone) begin
      data[latIdx][vicWay][cnt] <= iload;
      if (lastWord) tags[latIdx][vicWay] <= latTag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hitCnt;
  logic [31:0] missCnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hitCnt  <= '0;
      missCnt <= '0;
    end else begin
      if (fetchHit && (hitCnt != 32'hFFFF_FFFF)) hitCnt <= hitCnt + 32'd1;
      if (missStart && (missCnt != 32'hFFFF_FFFF)) missCnt <= missCnt + 32'd1;
    end
  end

  assign hit_count  = hitCnt;
  assign miss_count = missCnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc (SETS=8, WAYS=2, WORDS=2, two wait cycles per refill word).
`timescale 1ns/1ps
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        dbgState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fill_q[$];
  int exp_hits = 0;
  int exp_miss = 0;
  int wait_cnt = 0;
  bit ok;

  always #5 CLK = ~CLK;

  icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count),
    .dbgState(dbgState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Memory controller model: two busy cycles, then one data cycle per word.
  initial begin
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (iREN && wait_cnt < 2) begin
        iwait = 1'b1;
        wait_cnt++;
      end else if (iREN) begin
        iwait    = 1'b0;
        iload    = {16'hC0DE, iaddr[15:0]};
        wait_cnt = 0;
      end else begin
        iwait    = 1'b1;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a hit or a refill beat.
  initial begin
    forever begin
      @(negedge CLK);
      if (ihit === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hit: got imemload 0x%08h, expected no hit", imemload);
        end else begin
          check("imemload", imemload, exp_q.pop_front());
        end
      end
      if (iREN === 1'b1 && iwait === 1'b0) begin
        if (exp_fill_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_refill: got iaddr 0x%08h, expected no refill", iaddr);
        end else begin
          check("refill_iaddr", iaddr, exp_fill_q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the hit cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input bit miss);
    int lat;
    int ren;
    bit got;
    exp_q.push_back(word);
    if (miss) begin
      exp_fill_q.push_back({addr[31:3], 3'b000});
      exp_fill_q.push_back({addr[31:3], 3'b100});
      exp_miss++;
    end
    exp_hits++;
    imemREN  = 1'b1;
    imemaddr = addr;
    lat = 0; ren = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge CLK);
      if (iREN) ren++;
      if (ihit) got = 1'b1;
      else lat++;
    end
    check("hit_seen", {31'd0, got}, 32'd1);
    check("hit_latency", lat, miss ? 32'd7 : 32'd0);
    check("iren_cycles", ren, miss ? 32'd6 : 32'd0);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  task automatic wait_land();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (iREN && !iwait) ok = 1'b1;
    end
    check("land_seen", {31'd0, ok}, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_stats(input string name);
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    check({name, "_hits"}, hit_count, exp_hits);
    check({name, "_misses"}, miss_count, exp_miss);
`else
    check({name, "_hits"}, hit_count, 32'd0);
    check({name, "_misses"}, miss_count, 32'd0);
`endif
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_ihit", {31'd0, ihit}, 32'd0);
    check("reset_iren", {31'd0, iREN}, 32'd0);
    check("reset_imemload", imemload, 32'd0);
    check("reset_state", {31'd0, dbgState}, 32'd0);
    check("reset_hit_count", hit_count, 32'd0);
    check("reset_miss_count", miss_count, 32'd0);
    @(posedge CLK);
    #1;

    // Cold miss, then same-block hit.
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b1);
    fetch(32'h0000_0044, 32'hC0DE_0044, 1'b0);

    // LRU in set 0.
    fetch(32'h0000_0440, 32'hC0DE_0440, 1'b1);
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b0);
    fetch(32'h0000_0840, 32'hC0DE_0840, 1'b1);
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b0);
    fetch(32'h0000_0440, 32'hC0DE_0440, 1'b1);

    // Address change mid-fill: 0x80 block completes, then 0x100 refills.
    exp_fill_q.push_back(32'h80);
    exp_fill_q.push_back(32'h84);
    exp_fill_q.push_back(32'h100);
    exp_fill_q.push_back(32'h104);
    exp_q.push_back(32'hC0DE_0100);
    exp_miss += 2;
    exp_hits += 1;
    imemREN = 1'b1;
    imemaddr = 32'h80;
    wait_land();
    imemaddr = 32'h100;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (ihit) ok = 1'b1;
    end
    check("addr_change_hit", {31'd0, ok}, 32'd1);
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
    fetch(32'h0000_0084, 32'hC0DE_0084, 1'b0);

    // Hit and flush in the same cycle: flush wins.
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b1);
    imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b1;
    @(negedge CLK);
    check("hit_flush_ihit", {31'd0, ihit}, 32'd0);
    check("hit_flush_imemload", imemload, 32'd0);
    @(posedge CLK);
    #1;
    iflush = 1'b0; imemREN = 1'b0;
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b1);

    // Flush during a fill of 0xC0.
    exp_fill_q.push_back(32'hC0);
    exp_miss++;
    imemREN = 1'b1;
    imemaddr = 32'hC0;
    wait_land();
    iflush = 1'b1; imemREN = 1'b0;
    @(posedge CLK);
    #1;
    iflush = 1'b0;
    @(negedge CLK);
    check("flush_iren", {31'd0, iREN}, 32'd0);
    check("flush_state", {31'd0, dbgState}, 32'd0);
    @(posedge CLK);
    #1;
    fetch(32'h0000_0040, 32'hC0DE_0040, 1'b1);
    fetch(32'h0000_00C0, 32'hC0DE_00C0, 1'b1);

    // Reset in the cycle after the first refill word lands.
    exp_fill_q.push_back(32'h140);
    imemREN = 1'b1;
    imemaddr = 32'h140;
    wait_land();
    RST = 1'b1; imemREN = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    @(negedge CLK);
    check("rst_fill_iren", {31'd0, iREN}, 32'd0);
    check("rst_fill_ihit", {31'd0, ihit}, 32'd0);
    check("rst_fill_hit_count", hit_count, 32'd0);
    check("rst_fill_miss_count", miss_count, 32'd0);
    @(posedge CLK);
    #1;
    fetch(32'h0000_0140, 32'hC0DE_0140, 1'b1);

    // Statistics: 3 miss fetches plus 2 hit fetches give 5 hit cycles.
    fetch(32'h0000_0144, 32'hC0DE_0144, 1'b0);
    fetch(32'h0000_0208, 32'hC0DE_0208, 1'b1);
    fetch(32'h0000_020C, 32'hC0DE_020C, 1'b0);
    fetch(32'h0000_0210, 32'hC0DE_0210, 1'b1);
    check_stats("stats");
    iflush = 1'b1;
    @(posedge CLK);
    #1;
    iflush = 1'b0;
    check_stats("stats_after_flush");
    fetch(32'h0000_0144, 32'hC0DE_0144, 1'b1);
    check_stats("stats_final");

    repeat (2) @(posedge CLK);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_fill_q_drained", exp_fill_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
